// File: rtl/xor_stream_descrambler.sv
// XOR stream descrambler: a 16-bit Fibonacci LFSR keystream is XORed onto each accepted word.
// A seed load is deferred through DRAIN while an output word is still waiting, so that word is never lost.
module xor_stream_descrambler #(
    parameter int          WIDTH        = 4,
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             seed_load,
    input  logic [15:0]      seed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic [15:0]      word_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]       state_reg;
    logic [15:0]      lfsr_reg;
    logic [15:0]      seed_latch_reg;
    logic [15:0]      word_count_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;

    logic             accept;
    logic             out_fire;
    logic [15:0]      lfsr_chain [0:WIDTH];

    // An all-zero seed would lock the LFSR, so it is replaced by the default.
    function automatic logic [15:0] fix_seed(input logic [15:0] s);
        return (s == 16'h0000) ? SEED_DEFAULT : s;
    endfunction

    // Unrolled LFSR: WIDTH single steps chained so one word advances WIDTH steps in one cycle.
    assign lfsr_chain[0] = lfsr_reg;
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lfsr_step
            assign lfsr_chain[gi+1] = {lfsr_chain[gi][0] ^ lfsr_chain[gi][2] ^
                                       lfsr_chain[gi][3] ^ lfsr_chain[gi][5],
                                       lfsr_chain[gi][15:1]};
        end
    endgenerate

    assign in_ready   = (state_reg == RUN) && !seed_load && (!out_valid_reg || out_ready);
    assign accept     = in_valid && in_ready;
    assign out_fire   = out_valid_reg && out_ready;
    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign busy       = (state_reg != IDLE);
    assign word_count = word_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            lfsr_reg       <= SEED_DEFAULT;
            seed_latch_reg <= 16'h0000;
            word_count_reg <= 16'h0000;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
        end else begin
            if (out_fire) begin
                out_valid_reg <= 1'b0;
            end
            // accept is only possible in RUN without seed_load, so it never collides with a reload.
            if (accept) begin
                out_valid_reg  <= 1'b1;
                out_data_reg   <= in_data ^ lfsr_reg[WIDTH-1:0];
                lfsr_reg       <= lfsr_chain[WIDTH];
                word_count_reg <= word_count_reg + 16'd1;
            end
            case (state_reg)
                IDLE: begin
                    if (seed_load) begin
                        lfsr_reg       <= fix_seed(seed);
                        word_count_reg <= 16'h0000;
                        state_reg      <= RUN;
                    end
                end
                RUN: begin
                    if (seed_load) begin
                        if (!out_valid_reg) begin
                            lfsr_reg       <= fix_seed(seed);
                            word_count_reg <= 16'h0000;
                        end else begin
                            seed_latch_reg <= seed;
                            state_reg      <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (seed_load) begin
                        seed_latch_reg <= seed;
                    end
                    // A seed arriving on the completing cycle is the newest one and wins.
                    if (!out_valid_reg || out_ready) begin
                        lfsr_reg       <= fix_seed(seed_load ? seed : seed_latch_reg);
                        word_count_reg <= 16'h0000;
                        state_reg      <= RUN;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_stream_descrambler.sv
// Bench for xor_stream_descrambler: directed scenarios plus randomized streams checked
// against a keystream model built from the LFSR bit-sequence recurrence.
module tb_xor_stream_descrambler;

    localparam int W = 4;
    localparam int N_SERIES = 1000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          seed_load = 1'b0;
    logic [15:0]   seed = 16'h0000;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          out_ready = 1'b0;
    logic          in_ready, out_valid, busy;
    logic [W-1:0]  out_data;
    logic [15:0]   word_count;

    logic          series = 1'b0;
    logic          a_out_ready;
    logic          b_in_valid;
    logic          b_in_ready, b_out_valid, b_busy;
    logic          b_out_ready = 1'b0;
    logic [W-1:0]  b_out_data;
    logic [15:0]   b_word_count;

    int vectors = 0;
    int miscompares = 0;

    // Keystream model: bit sequence s[n+16] = s[n]^s[n+2]^s[n+3]^s[n+5], word k = s[kW .. kW+W-1].
    bit ks[$];
    int ks_pos;

    assign a_out_ready = series ? b_in_ready : out_ready;
    assign b_in_valid  = series && out_valid;

    always #5 clk = ~clk;

    xor_stream_descrambler #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(a_out_ready), .out_data(out_data),
        .busy(busy), .word_count(word_count)
    );

    xor_stream_descrambler #(.WIDTH(W)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(out_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .busy(b_busy), .word_count(b_word_count)
    );

    function automatic void model_seed(input logic [15:0] s);
        logic [15:0] v;
        v = (s == 16'h0000) ? 16'hACE1 : s;
        ks.delete();
        for (int i = 0; i < 16; i++) ks.push_back(v[i]);
        ks_pos = 0;
    endfunction

    function automatic logic [W-1:0] model_word();
        logic [W-1:0] w;
        int n;
        while (ks.size() < ks_pos + W) begin
            n = ks.size();
            ks.push_back(ks[n-16] ^ ks[n-14] ^ ks[n-13] ^ ks[n-11]);
        end
        for (int i = 0; i < W; i++) w[i] = ks[ks_pos+i];
        ks_pos += W;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_seed(input logic [15:0] s);
        seed_load = 1'b1;
        seed = s;
        model_seed(s);
        tick();
        seed_load = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        vectors++; if (word_count !== 16'h0) begin miscompares++; $display("FAIL reset_word_count got=%h want=0000", word_count); end
        vectors++; if (out_data !== 4'h0) begin miscompares++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        tick();
        rst_n = 1'b1;
        in_valid = 1'b1;
        tick();
        vectors++; if (busy !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL idle_after_reset busy=%b in_ready=%b want 0/0", busy, in_ready); end
        in_valid = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        load_seed(16'h0001);
        vectors++; if (busy !== 1'b1 || word_count !== 16'h0) begin miscompares++; $display("FAIL basic_loaded busy=%b wc=%h want 1/0000", busy, word_count); end
        in_valid = 1'b1;
        in_data = 4'h5;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL basic_in_ready got=%b want=1", in_ready); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_data !== 4'h4) begin miscompares++; $display("FAIL basic_word0 valid=%b data=%h want 1/4", out_valid, out_data); end
        tick();
        vectors++; if (out_valid !== 1'b1 || out_data !== 4'h5) begin miscompares++; $display("FAIL basic_word1 valid=%b data=%h want 1/5", out_valid, out_data); end
        in_valid = 1'b0;
        tick();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_out_clear got=%b want=0", out_valid); end
        vectors++; if (word_count !== 16'd2) begin miscompares++; $display("FAIL basic_word_count got=%0d want=2", word_count); end
        $display("test_basic done: words 5,5 -> 4,5");
    endtask

    task automatic test_zero_seed();
        out_ready = 1'b1;
        load_seed(16'h0000);
        in_valid = 1'b1;
        in_data = 4'h0;
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_data !== 4'h1) begin miscompares++; $display("FAIL zero_seed valid=%b data=%h want 1/1", out_valid, out_data); end
        tick();
        $display("test_zero_seed done");
    endtask

    task automatic test_stall();
        logic [W-1:0] d, expd;
        int fires;
        out_ready = 1'b0;
        load_seed(16'($urandom_range(1, 16'hFFFF)));
        d = W'($urandom);
        expd = d ^ model_word();
        in_valid = 1'b1;
        in_data = d;
        tick();
        in_data = ~d;
        for (int i = 0; i < 10; i++) begin
            vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== expd) begin
                miscompares++; $display("FAIL stall_hold cyc=%0d in_ready=%b valid=%b data=%h want 0/1/%h", i, in_ready, out_valid, out_data, expd);
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        fires = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) fires++;
            tick();
        end
        vectors++; if (fires != 1) begin miscompares++; $display("FAIL stall_release handshakes=%0d want=1", fires); end
        vectors++; if (word_count !== 16'd1) begin miscompares++; $display("FAIL stall_word_count got=%0d want=1", word_count); end
        $display("test_stall done: word %h held 10 cycles", expd);
    endtask

    task automatic test_drain();
        logic [W-1:0] d, expd;
        out_ready = 1'b0;
        load_seed(16'h1234);
        d = W'($urandom);
        expd = d ^ model_word();
        in_valid = 1'b1;
        in_data = d;
        tick();
        seed_load = 1'b1;
        seed = 16'h9ABC;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL drain_req_in_ready got=%b want=0", in_ready); end
        tick();
        seed_load = 1'b0;
        vectors++; if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== expd) begin
            miscompares++; $display("FAIL drain_state busy=%b in_ready=%b valid=%b data=%h want 1/0/1/%h", busy, in_ready, out_valid, out_data, expd);
        end
        seed_load = 1'b1;
        seed = 16'h5678;
        tick();
        seed_load = 1'b0;
        out_ready = 1'b1;
        #1;
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL drain_ready_blocked got=%b want=0", in_ready); end
        tick();
        vectors++; if (out_valid !== 1'b0 || word_count !== 16'h0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL drain_done valid=%b wc=%h busy=%b want 0/0000/1", out_valid, word_count, busy);
        end
        model_seed(16'h5678);
        d = W'($urandom);
        expd = d ^ model_word();
        in_data = d;
        #1;
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL drain_run_ready got=%b want=1", in_ready); end
        tick();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || out_data !== expd) begin miscompares++; $display("FAIL drain_last_seed valid=%b data=%h want 1/%h", out_valid, out_data, expd); end
        tick();
        $display("test_drain done");
    endtask

    task automatic test_random_stream();
        logic [W-1:0] expq[$];
        logic [W-1:0] d, got, want;
        logic acc, fire;
        int nacc = 0;
        load_seed(16'($urandom));
        for (int cyc = 0; cyc < 300; cyc++) begin
            d = W'($urandom);
            in_valid = ($urandom_range(3) != 0);
            in_data = d;
            out_ready = ($urandom_range(2) != 0);
            #1;
            acc = in_valid && in_ready;
            fire = out_valid && out_ready;
            got = out_data;
            if (fire) begin
                want = (expq.size() > 0) ? expq.pop_front() : ~got;
                vectors++; if (got !== want) begin miscompares++; $display("FAIL random_word got=%h want=%h", got, want); end
            end
            if (acc) begin
                expq.push_back(d ^ model_word());
                nacc++;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        if (out_valid) begin
            want = (expq.size() > 0) ? expq.pop_front() : ~out_data;
            vectors++; if (out_data !== want) begin miscompares++; $display("FAIL random_tail got=%h want=%h", out_data, want); end
        end
        tick();
        vectors++; if (expq.size() != 0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL random_drain left=%0d valid=%b want 0/0", expq.size(), out_valid); end
        vectors++; if (word_count !== 16'(nacc)) begin miscompares++; $display("FAIL random_word_count got=%0d want=%0d", word_count, nacc); end
        $display("test_random_stream done: %0d words", nacc);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        load_seed(16'hC0DE);
        in_valid = 1'b1;
        in_data = W'($urandom);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++; $display("FAIL reset_mid valid=%b busy=%b in_ready=%b want 0/0/0", out_valid, busy, in_ready);
        end
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
                miscompares++; $display("FAIL reset_mid_idle cyc=%0d in_ready=%b valid=%b busy=%b want 0/0/0", i, in_ready, out_valid, busy);
            end
        end
        in_valid = 1'b0;
        $display("test_reset_mid done");
    endtask

    task automatic test_series();
        logic [W-1:0] words[$];
        logic [W-1:0] expq[$];
        logic [W-1:0] a_data, b_data, want;
        logic a_acc, a_fire, b_fire;
        int sent = 0, recv = 0, cyc = 0;
        for (int i = 0; i < N_SERIES; i++) words.push_back(W'($urandom));
        series = 1'b1;
        load_seed(16'hBEEF);
        while (recv < N_SERIES && cyc < 30000) begin
            in_valid = (sent < N_SERIES) && ($urandom_range(3) != 0);
            in_data = (sent < N_SERIES) ? words[sent] : '0;
            b_out_ready = ($urandom_range(3) != 0);
            #1;
            a_acc = in_valid && in_ready;
            a_fire = out_valid && b_in_ready;
            b_fire = b_out_valid && b_out_ready;
            a_data = out_data;
            b_data = b_out_data;
            if (a_fire) begin
                want = (expq.size() > 0) ? expq.pop_front() : ~a_data;
                vectors++; if (a_data !== want) begin miscompares++; $display("FAIL series_stage_a idx=%0d got=%h want=%h", recv, a_data, want); end
            end
            if (a_acc) begin
                expq.push_back(words[sent] ^ model_word());
                sent++;
            end
            if (b_fire) begin
                vectors++; if (b_data !== words[recv]) begin miscompares++; $display("FAIL series_roundtrip idx=%0d got=%h want=%h", recv, b_data, words[recv]); end
                recv++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        vectors++; if (recv != N_SERIES) begin miscompares++; $display("FAIL series_timeout received=%0d want=%0d", recv, N_SERIES); end
        tick();
        vectors++; if (word_count !== 16'(N_SERIES) || b_word_count !== 16'(N_SERIES)) begin
            miscompares++; $display("FAIL series_word_count a=%0d b=%0d want=%0d", word_count, b_word_count, N_SERIES);
        end
        series = 1'b0;
        $display("test_series done: %0d words in %0d cycles", recv, cyc);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_seed();
        test_stall();
        test_drain();
        test_random_stream();
        test_reset_mid();
        test_series();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/xor_stream_descrambler.md
XOR_STREAM_DESCRAMBLER -- requirements
Module: xor_stream_descrambler

Interface
REQ-001 Parameter WIDTH, default 4, data word width in bits; legal range 1..16.
REQ-002 Parameter SEED_DEFAULT, default 16'hACE1, LFSR value substituted for an all-zero seed.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port seed_load, input, 1, request to load seed into the keystream LFSR.
REQ-006 Port seed, input, 16, keystream seed sampled when seed_load is high.
REQ-007 Port in_valid, input, 1, in_data holds a scrambled word.
REQ-008 Port in_ready, output, 1, block accepts in_data this cycle.
REQ-009 Port in_data, input, WIDTH, scrambled word.
REQ-010 Port out_valid, output, 1, out_data holds a descrambled word.
REQ-011 Port out_ready, input, 1, downstream accepts out_data this cycle.
REQ-012 Port out_data, output, WIDTH, descrambled word.
REQ-013 Port busy, output, 1, high when state is not IDLE.
REQ-014 Port word_count, output, 16, number of words accepted since the last seed load.

Function
REQ-015 LFSR SHALL be 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1; one step: fb = l[0]^l[2]^l[3]^l[5]; l = {fb, l[15:1]}.
REQ-016 Keystream word SHALL be lfsr[WIDTH-1:0]; on each accepted input word the LFSR SHALL advance exactly WIDTH steps in that cycle.
REQ-017 A load of seed == 16'h0000 SHALL load SEED_DEFAULT instead, so the LFSR never locks up.
REQ-018 Input handshake: a word is accepted when in_valid && in_ready at a rising edge.
REQ-019 in_ready = (state == RUN) && !seed_load && (!out_valid || out_ready), combinationally.
REQ-020 On acceptance, out_data SHALL register in_data ^ keystream and out_valid SHALL be 1 on the next cycle: latency 1 cycle, throughput 1 word per cycle.
REQ-021 out_valid SHALL stay high and out_data stable until out_ready is high; out_valid clears after a handshake with no new acceptance.
REQ-022 The FSM SHALL have three states: IDLE, RUN, DRAIN.
REQ-023 IDLE: in_ready = 0. seed_load SHALL load the LFSR, clear word_count and move to RUN.
REQ-024 RUN with seed_load && !out_valid: load the LFSR, clear word_count, stay in RUN; no word is accepted in that cycle.
REQ-025 RUN with seed_load && out_valid: latch seed internally and move to DRAIN.
REQ-026 DRAIN: in_ready = 0. When the pending output completes its handshake (or out_valid is already 0), load the latched seed, clear word_count and move to RUN.
REQ-027 A seed_load in DRAIN SHALL overwrite the latched seed; the last value wins.
REQ-028 Seed load and input handshake can never occur in the same cycle; seed_load has priority (REQ-019).
REQ-029 word_count SHALL increment by 1 per accepted word and wrap 16'hFFFF -> 16'h0000 without a flag.
REQ-030 The block SHALL be self-inverse: two instances with equal seeds in series reproduce the original stream.

Reset
REQ-031 rst_n low SHALL immediately force: state = IDLE, lfsr = SEED_DEFAULT, out_valid = 0, out_data = 0, word_count = 0, busy = 0, in_ready = 0, latched seed = 0.
REQ-032 Reset asserted mid-stream SHALL discard any pending output word; after release the block waits in IDLE for seed_load.
REQ-033 Deassertion of rst_n SHALL need no other input activity; the first rising edge after deassertion behaves as IDLE.

Verification (WIDTH=4)
REQ-034 Reset, then seed_load with seed=16'h0001, then words 4'h5, 4'h5 back-to-back with out_ready=1 -> out_data 4'h4 then 4'h5 (LFSR 0x0001 -> 0x1000); word_count=2.
REQ-035 seed_load with seed=16'h0000, then in_data 4'h0 -> out_data 4'h1 (SEED_DEFAULT low nibble).
REQ-036 Hold out_ready=0 after one accepted word -> in_ready=0, out_valid held, out_data stable for 10 cycles; release -> exactly one output handshake.
REQ-037 Assert seed_load while out_valid=1 and out_ready=0 -> DRAIN, in_ready=0; on the output handshake the new seed loads, state is RUN and word_count=0.
REQ-038 Two instances in series, equal seed 16'hBEEF, 1000 random words with random stalls -> output equals input; word_count=1000 on both.
REQ-039 Assert rst_n low mid-stream with out_valid=1 -> out_valid=0 and busy=0 with no clock edge; in_ready stays 0 until the next seed_load.
